// File: rtl/obstacle_scroller_pkg.sv
// Shared types and screen constants for the obstacle scroller and its neighbours.
package obstacle_scroller_pkg;

  localparam int unsigned COORD_W     = 10;
  localparam int unsigned SPEED_W     = 4;
  localparam int unsigned SCREEN_W    = 640;
  localparam int unsigned OFFSCREEN_X = 643;
  localparam int unsigned DEF_MIN_Y   = 40;
  localparam int unsigned DEF_MAX_Y   = 439;

  typedef logic [COORD_W-1:0] coord_t;

  // Scroller FSM encoding
  typedef logic [1:0] state_t;
  localparam state_t IDLE   = 2'd0;
  localparam state_t SCROLL = 2'd1;
  localparam state_t REQ    = 2'd2;

endpackage

// File: rtl/obstacle_scroller_if.sv
// Obstacle-height request/response link between a scroller and a height generator.
interface obstacle_scroller_if;
  import obstacle_scroller_pkg::*;

  logic   height_req;
  coord_t height_in;
  logic   height_valid;

  modport master (output height_req, input height_in, input height_valid);
  modport slave  (input height_req, output height_in, output height_valid);

endinterface

// File: rtl/obstacle_scroller_height_clamp.sv
// Combinational saturating clamp of a 10-bit coordinate into [MIN_V, MAX_V].
module obstacle_scroller_height_clamp
  import obstacle_scroller_pkg::*;
#(
  parameter int unsigned MIN_V = DEF_MIN_Y,
  parameter int unsigned MAX_V = DEF_MAX_Y
) (
  input  coord_t value,
  output coord_t value_c
);

  localparam coord_t LO = COORD_W'(MIN_V);
  localparam coord_t HI = COORD_W'(MAX_V);

  // Saturate against the unsigned bounds
  always_comb begin
    value_c = value;
    if (value < LO) begin
      value_c = LO;
    end else if (value > HI) begin
      value_c = HI;
    end
  end

endmodule

// File: rtl/obstacle_scroller.sv
// One obstacle's horizontal motion, respawn and new-height request handshake.
module obstacle_scroller
  import obstacle_scroller_pkg::*;
#(
  parameter int unsigned START_X        = 700,
  parameter int unsigned START_Y        = 150,
  parameter int unsigned MIN_Y          = DEF_MIN_Y,
  parameter int unsigned MAX_Y          = DEF_MAX_Y,
  parameter int unsigned PLAYER_X       = 100,
  parameter int unsigned TIMEOUT_FRAMES = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_tick,
  input  logic                enable,
  input  logic [SPEED_W-1:0]  speed,
  obstacle_scroller_if.master hgt,
  output coord_t              x,
  output coord_t              y,
  output logic                active,
  output logic                pass_pulse
);

  localparam int unsigned CNT_W = (TIMEOUT_FRAMES < 2) ? 1 : $clog2(TIMEOUT_FRAMES + 1);
  localparam coord_t      X0    = COORD_W'(START_X);
  localparam coord_t      Y0    = COORD_W'(START_Y);
  localparam coord_t      PX    = COORD_W'(PLAYER_X);
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_FRAMES);

  state_t           state_q, state_d;
  coord_t           x_d, y_d;
  logic             req_d, pass_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  coord_t           speed_w;
  coord_t           height_clamped_c;

  assign speed_w = COORD_W'(speed);

  obstacle_scroller_height_clamp #(
    .MIN_V (MIN_Y),
    .MAX_V (MAX_Y)
  ) u_clamp (
    .value   (hgt.height_in),
    .value_c (height_clamped_c)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    x_d     = x;
    y_d     = y;
    req_d   = hgt.height_req;
    pass_d  = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (enable) state_d = SCROLL;
      end
      SCROLL: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (frame_tick) begin
          if (x >= speed_w) begin
            x_d    = x - speed_w;
            pass_d = (x >= PX) && (x_d < PX);
          end else begin
            // Left exit: park off-screen right and ask for a new height
            x_d     = X0;
            req_d   = 1'b1;
            cnt_d   = '0;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        x_d   = X0;
        req_d = 1'b1;
        if (hgt.height_valid) begin
          y_d     = height_clamped_c;
          req_d   = 1'b0;
          state_d = enable ? SCROLL : IDLE;
        end else if (frame_tick) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d >= TO_LIM) begin
            // Generator too slow: keep the previous height
            req_d   = 1'b0;
            state_d = enable ? SCROLL : IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      x              <= X0;
      y              <= Y0;
      hgt.height_req <= 1'b0;
      pass_pulse     <= 1'b0;
      active         <= 1'b0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      x              <= x_d;
      y              <= y_d;
      hgt.height_req <= req_d;
      pass_pulse     <= pass_d;
      active         <= (state_d != IDLE);
      cnt_q          <= cnt_d;
    end
  end

endmodule

// File: tb/tb_obstacle_scroller.sv
// Randomised and directed bench for obstacle_scroller against a behavioural model.
module tb_obstacle_scroller;

  localparam int START_X  = 700;
  localparam int START_Y  = 150;
  localparam int MIN_Y    = 40;
  localparam int MAX_Y    = 439;
  localparam int PLAYER_X = 100;
  localparam int TIMEOUT  = 8;

  localparam int M_STOPPED = 0;
  localparam int M_MOVING  = 1;
  localparam int M_WAITING = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       enable;
  logic [3:0] speed;
  logic [9:0] x, y;
  logic       active, pass_pulse;

  int total = 0;
  int bad   = 0;

  obstacle_scroller_if hif ();

  obstacle_scroller dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .enable     (enable),
    .speed      (speed),
    .hgt        (hif),
    .x          (x),
    .y          (y),
    .active     (active),
    .pass_pulse (pass_pulse)
  );

  always #5 clk = ~clk;

  // Behavioural reference: what the obstacle should be doing, in plain integers
  int m_mode, m_x, m_y, m_waited;
  bit m_req, m_pass, m_active;

  always @(posedge clk) begin
    int old_x;
    if (reset) begin
      m_mode = M_STOPPED; m_x = START_X; m_y = START_Y;
      m_req = 0; m_pass = 0; m_waited = 0;
    end else begin
      m_pass = 0;
      if (m_mode == M_STOPPED) begin
        if (enable) m_mode = M_MOVING;
      end else if (m_mode == M_MOVING) begin
        if (!enable) m_mode = M_STOPPED;
        else if (frame_tick) begin
          if (int'(speed) > m_x) begin
            m_x = START_X; m_req = 1; m_waited = 0; m_mode = M_WAITING;
          end else begin
            old_x = m_x;
            m_x = m_x - int'(speed);
            m_pass = (old_x >= PLAYER_X) && (m_x < PLAYER_X);
          end
        end
      end else begin
        if (hif.height_valid) begin
          m_y = int'(hif.height_in);
          if (m_y < MIN_Y) m_y = MIN_Y;
          if (m_y > MAX_Y) m_y = MAX_Y;
          m_req = 0; m_mode = enable ? M_MOVING : M_STOPPED;
        end else if (frame_tick) begin
          m_waited++;
          if (m_waited == TIMEOUT) begin
            m_req = 0; m_mode = enable ? M_MOVING : M_STOPPED;
          end
        end
      end
    end
    m_active = (m_mode != M_STOPPED);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int spd);
    frame_tick = 1'b1;
    speed = 4'(spd);
    step();
    frame_tick = 1'b0;
  endtask

  // Scroll down to an exact x using the model's position
  task automatic goto_x(input int target);
    int n = 0;
    while (m_x != target && n < 200) begin
      tick((m_x - target > 15) ? 15 : (m_x - target));
      n++;
    end
    total++;
    if (m_x != target || x !== 10'(target)) begin
      bad++;
      $display("FAIL goto_x: x=%0d model=%0d target=%0d", x, m_x, target);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; frame_tick = 1'b0; enable = 1'b0; speed = 4'd0;
    hif.height_valid = 1'b0; hif.height_in = 10'd0;
    step(); step();
    reset = 1'b0;
    total++;
    if ({x, y, hif.height_req, active, pass_pulse} !== {10'd700, 10'd150, 3'b000}) begin
      bad++;
      $display("FAIL reset_state: x=%0d y=%0d req=%b act=%b pass=%b", x, y, hif.height_req, active, pass_pulse);
    end
  endtask

  task automatic test_scroll_basic();
    enable = 1'b1;
    step();
    total++;
    if (x !== 10'd700 || active !== 1'b1) begin
      bad++;
      $display("FAIL scroll_start: x=%0d act=%b exp x=700 act=1", x, active);
    end
    for (int i = 1; i <= 3; i++) begin
      tick(5);
      total++;
      if (x !== 10'(700 - 5 * i) || y !== 10'd150 || hif.height_req !== 1'b0) begin
        bad++;
        $display("FAIL scroll_tick%0d: x=%0d y=%0d req=%b exp x=%0d y=150 req=0", i, x, y, hif.height_req, 700 - 5 * i);
      end
    end
  endtask

  task automatic test_pass_pulse();
    goto_x(103);
    tick(4);
    total++;
    if (x !== 10'd99 || pass_pulse !== 1'b1) begin
      bad++;
      $display("FAIL pass_fire: x=%0d pass=%b exp x=99 pass=1", x, pass_pulse);
    end
    step();
    total++;
    if (pass_pulse !== 1'b0) begin
      bad++;
      $display("FAIL pass_width: pass=%b exp 0", pass_pulse);
    end
    tick(4);
    total++;
    if (x !== 10'd95 || pass_pulse !== 1'b0) begin
      bad++;
      $display("FAIL pass_after: x=%0d pass=%b exp x=95 pass=0", x, pass_pulse);
    end
  endtask

  task automatic respawn_with(input int h, input int exp_y, input string nm);
    goto_x(3);
    tick(4);
    total++;
    if (x !== 10'd700 || hif.height_req !== 1'b1 || active !== 1'b1) begin
      bad++;
      $display("FAIL %s_respawn: x=%0d req=%b act=%b exp x=700 req=1 act=1", nm, x, hif.height_req, active);
    end
    step(); step();
    hif.height_valid = 1'b1; hif.height_in = 10'(h);
    step();
    hif.height_valid = 1'b0;
    total++;
    if (y !== 10'(exp_y) || hif.height_req !== 1'b0 || active !== 1'b1 || x !== 10'd700) begin
      bad++;
      $display("FAIL %s_accept: y=%0d req=%b act=%b x=%0d exp y=%0d req=0 act=1 x=700", nm, y, hif.height_req, active, x, exp_y);
    end
    tick(5);
    total++;
    if (x !== 10'd695) begin
      bad++;
      $display("FAIL %s_resume: x=%0d exp 695", nm, x);
    end
  endtask

  task automatic test_respawn_accept();
    respawn_with(250, 250, "accept");
  endtask

  task automatic test_clamp();
    respawn_with(20, MIN_Y, "clamp_lo");
    respawn_with(600, MAX_Y, "clamp_hi");
  endtask

  task automatic test_reset_mid_req();
    goto_x(3);
    tick(4);
    hif.height_valid = 1'b1; hif.height_in = 10'd300; reset = 1'b1;
    step();
    hif.height_valid = 1'b0; reset = 1'b0; enable = 1'b0;
    total++;
    if ({x, y, hif.height_req, active} !== {10'd700, 10'd150, 2'b00}) begin
      bad++;
      $display("FAIL reset_mid_req: x=%0d y=%0d req=%b act=%b exp 700 150 0 0", x, y, hif.height_req, active);
    end
  endtask

  task automatic test_timeout();
    enable = 1'b1;
    step();
    goto_x(3);
    tick(4);
    for (int i = 1; i < TIMEOUT; i++) begin
      tick(3);
      total++;
      if (hif.height_req !== 1'b1 || x !== 10'd700) begin
        bad++;
        $display("FAIL timeout_wait%0d: req=%b x=%0d exp req=1 x=700", i, hif.height_req, x);
      end
    end
    tick(3);
    total++;
    if (hif.height_req !== 1'b0 || y !== 10'd150 || active !== 1'b1 || x !== 10'd700) begin
      bad++;
      $display("FAIL timeout_expire: req=%b y=%0d act=%b x=%0d exp 0 150 1 700", hif.height_req, y, active, x);
    end
    tick(5);
    total++;
    if (x !== 10'd695) begin
      bad++;
      $display("FAIL timeout_resume: x=%0d exp 695", x);
    end
  endtask

  task automatic test_freeze();
    enable = 1'b0;
    tick(7);
    total++;
    if (x !== 10'd695 || active !== 1'b0) begin
      bad++;
      $display("FAIL freeze: x=%0d act=%b exp x=695 act=0", x, active);
    end
    tick(7);
    enable = 1'b1;
    step();
    tick(0);
    tick(0);
    total++;
    if (x !== 10'd695 || pass_pulse !== 1'b0 || active !== 1'b1) begin
      bad++;
      $display("FAIL speed_zero: x=%0d pass=%b act=%b exp 695 0 1", x, pass_pulse, active);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      reset            = ($urandom_range(0, 299) == 0);
      enable           = ($urandom_range(0, 19) != 0);
      frame_tick       = ($urandom_range(0, 1) == 1);
      speed            = 4'($urandom_range(0, 15));
      hif.height_valid = ($urandom_range(0, 9) == 0);
      hif.height_in    = 10'($urandom_range(0, 1023));
      step();
      total++;
      if ({x, y, hif.height_req, active, pass_pulse} !==
          {10'(m_x), 10'(m_y), m_req, m_active, m_pass}) begin
        bad++;
        $display("FAIL random_cycle%0d: x=%0d y=%0d req=%b act=%b pass=%b exp x=%0d y=%0d req=%b act=%b pass=%b",
                 i, x, y, hif.height_req, active, pass_pulse, m_x, m_y, m_req, m_active, m_pass);
      end
    end
    reset = 1'b0; frame_tick = 1'b0; hif.height_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scroll_basic();
    test_pass_pulse();
    test_respawn_accept();
    test_clamp();
    test_reset_mid_req();
    test_timeout();
    test_freeze();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/obstacle_scroller.md
Name: obstacle_scroller

Overview:
Owns one obstacle's horizontal motion and is the requesting side of the obstacle-height interface. Each frame it moves the obstacle left by a programmable speed. When the obstacle leaves the screen on the left, it parks the obstacle off-screen on the right and requests a new height over a req/valid handshake. It then resumes scrolling with the clamped height. Its outputs x/y feed the renderer and collision logic, and its pass pulse feeds the score counter.

Parameters:
START_X, 700, x on reset and after every respawn; must be > 642 (off-screen right)
START_Y, 150, y on reset and the fallback height
MIN_Y, 40, lowest legal y; height_in below this is clamped to it
MAX_Y, 439, highest legal y; height_in above this is clamped to it
PLAYER_X, 100, x column of the player; crossing it fires pass_pulse
TIMEOUT_FRAMES, 8, frame_ticks to wait in REQ before keeping the previous y

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
frame_tick  in  1  one-cycle pulse per video frame
enable  in  1  game running; low freezes motion
speed  in  4  pixels moved per frame_tick; 0 means no motion
height_in  in  10  new height from the height generator
height_valid  in  1  height_in is valid this cycle
height_req  out  1  request for a new height, held until accepted or timed out
x  out  10  obstacle x, registered
y  out  10  obstacle y, registered
active  out  1  high in SCROLL and REQ
pass_pulse  out  1  one-cycle pulse when the obstacle passes PLAYER_X

Behaviour:
- Reset, synchronous, on any cycle including mid-handshake:
  - state=IDLE, x=START_X, y=START_Y
  - height_req=0, pass_pulse=0, active=0, timeout counter=0
- All outputs are registered; changes are visible the cycle after the causing input.
- IDLE:
  - x and y hold.
  - enable=1 -> SCROLL next cycle. frame_tick is ignored in IDLE.
- SCROLL, on a frame_tick with enable=1:
  - If x >= speed: x <= x - speed.
  - If x < speed (left exit, no underflow): x <= START_X, height_req <= 1, counter <= 0, state -> REQ.
  - pass_pulse <= 1 for exactly one cycle when old x >= PLAYER_X and new x < PLAYER_X. A respawn never fires it.
  - speed=0: x holds and no pass_pulse.
- SCROLL with enable=0: state -> IDLE, x and y hold.
- REQ:
  - x is held at START_X and height_req stays 1.
  - On height_valid=1: y <= clamp(height_in, MIN_Y, MAX_Y), height_req <= 0, state -> SCROLL. Acceptance takes one cycle.
  - On each frame_tick without height_valid: counter += 1.
  - When counter reaches TIMEOUT_FRAMES: height_req <= 0, y holds its previous value, state -> SCROLL.
  - height_valid and frame_tick in the same cycle: the accept wins and the counter is not incremented.
  - enable=0 does not abort REQ. After the accept or the timeout, go to IDLE instead of SCROLL if enable is still 0.
- height_valid while not in REQ is ignored; y does not change.
- Clamp: comparisons are unsigned 10-bit; MIN_Y <= MAX_Y is required.
- x never wraps below 0 and never exceeds START_X.

Decomposition:
- Shared package holds:
  - state typedef {IDLE, SCROLL, REQ}
  - screen constants: SCREEN_W=640, OFFSCREEN_X=643, the default MIN_Y/MAX_Y
- One natural sub-module, height_clamp: combinational 10-bit saturating clamp, reused by other object blocks.
- The FSM, the x datapath and the timeout counter stay in obstacle_scroller.

Test Plan:
- Reset, raise enable, give 3 frame_ticks at speed=5 -> x=700,695,690,685; y=150; height_req=0.
- x=103, speed=4, one tick (PLAYER_X=100) -> x=99, pass_pulse high for exactly 1 cycle. A following tick gives x=95 with no pulse.
- x=3, speed=4, one tick -> x=700, height_req=1. height_valid=1 with height_in=250 two cycles later -> y=250, height_req=0 next cycle, state SCROLL.
- In REQ, height_in=20 -> y=40. Separately, height_in=600 -> y=439.
- In REQ, 8 frame_ticks with no valid -> height_req drops, y keeps its prior value (150), scrolling resumes at x=700.
- Assert reset mid-REQ with height_valid also high -> next cycle x=700, y=150, height_req=0, active=0. Also check that enable=0 in SCROLL freezes x and that speed=0 holds x.
